// File: rtl/alu_pkg.sv
// Shared types for the handshaked sequential ALU: opcodes, FSM states and the flag bundle.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_NOT = 4'd4,
    OP_XOR = 4'd5,
    OP_SRL = 4'd6,
    OP_SLL = 4'd7,
    OP_SRA = 4'd8,
    OP_SLA = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } alu_state_e;

  typedef struct packed {
    logic c;
    logic v;
    logic z;
    logic n;
  } alu_flags_t;

  function automatic logic is_shift(input logic [3:0] op);
    return op inside {OP_SRL, OP_SLL, OP_SRA, OP_SLA};
  endfunction

endpackage

// File: rtl/alu_seq_shifter.sv
// One-bit shift step: the FSM in alu_seq applies it once per SHIFT cycle.
module alu_seq_shifter
  import alu_pkg::*;
#(
  parameter int Nbits = 5
) (
  input  logic [3:0]       mode,
  input  logic             sign_in,
  input  logic [Nbits-1:0] data_in,
  output logic [Nbits-1:0] data_out,
  output logic             bit_out,
  output logic             sign_chg
);

  always_comb begin
    data_out = {data_in[Nbits-2:0], 1'b0};
    bit_out  = data_in[Nbits-1];
    sign_chg = data_in[Nbits-1] ^ data_in[Nbits-2];
    case (mode)
      OP_SRL: begin
        data_out = {1'b0, data_in[Nbits-1:1]};
        bit_out  = data_in[0];
        sign_chg = 1'b0;
      end
      // sign_in is the original A msb, so every step refills with the same value
      OP_SRA: begin
        data_out = {sign_in, data_in[Nbits-1:1]};
        bit_out  = data_in[0];
        sign_chg = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Registered, handshaked ALU: single-cycle arithmetic/logic, iterative one-bit-per-cycle shifts,
// with C/V/Z/N flags registered alongside the result.
module alu_seq
  import alu_pkg::*;
#(
  parameter int Nbits = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ALUop,
  input  logic [Nbits-1:0] A,
  input  logic [Nbits-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Nbits-1:0] OUT,
  output logic             Carry_Flag,
  output logic             Overflow_Flag,
  output logic             Zero_Flag,
  output logic             Negative_Flag
);

  localparam int SHW = $clog2(Nbits) + 1;
  localparam logic [Nbits-1:0] NB_W = Nbits[Nbits-1:0];

  alu_state_e       state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [Nbits-1:0] work_q, work_d;
  logic [Nbits-1:0] out_q, out_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             sign_q, sign_d;
  logic             v_acc_q, v_acc_d;
  alu_flags_t       flags_q, flags_d;

  logic             accept;
  logic [Nbits-1:0] b_eff;
  logic [Nbits:0]   sum;
  logic [Nbits-1:0] imm_res;
  logic             imm_c, imm_v;
  logic [Nbits-1:0] sh_out;
  logic             sh_bit, sh_chg;

  alu_seq_shifter #(.Nbits(Nbits)) u_shifter (
    .mode    (op_q),
    .sign_in (sign_q),
    .data_in (work_q),
    .data_out(sh_out),
    .bit_out (sh_bit),
    .sign_chg(sh_chg)
  );

  // Single-cycle result straight from the live operands; latched only on accept.
  always_comb begin
    b_eff   = (ALUop == OP_SUB) ? ~B : B;
    sum     = {1'b0, A} + {1'b0, b_eff} + {{Nbits{1'b0}}, (ALUop == OP_SUB)};
    imm_res = '0;
    imm_c   = 1'b0;
    imm_v   = 1'b0;
    case (ALUop)
      OP_ADD, OP_SUB: begin
        imm_res = sum[Nbits-1:0];
        imm_c   = sum[Nbits];
        imm_v   = (A[Nbits-1] == b_eff[Nbits-1]) && (sum[Nbits-1] != A[Nbits-1]);
      end
      OP_AND: imm_res = A & B;
      OP_OR:  imm_res = A | B;
      OP_NOT: imm_res = ~A;
      OP_XOR: imm_res = A ^ B;
      OP_SRL, OP_SLL, OP_SRA, OP_SLA: imm_res = A;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    work_d  = work_q;
    out_d   = out_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    v_acc_d = v_acc_q;
    flags_d = flags_q;

    in_ready = !rst && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
    accept   = in_valid && in_ready;

    case (state_q)
      SHIFT: begin
        work_d  = sh_out;
        cnt_d   = cnt_q - SHW'(1);
        v_acc_d = v_acc_q | sh_chg;
        if (cnt_q == SHW'(1)) begin
          state_d   = DONE;
          out_d     = sh_out;
          flags_d.c = sh_bit;
          flags_d.v = (op_q == OP_SLA) && (v_acc_q || sh_chg);
          flags_d.z = (sh_out == '0);
          flags_d.n = sh_out[Nbits-1];
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: ;
    endcase

    // An accept in DONE overrides the return to IDLE so back-to-back ops need no bubble.
    if (accept) begin
      op_d = ALUop;
      if (is_shift(ALUop) && (B != '0)) begin
        state_d = SHIFT;
        work_d  = A;
        sign_d  = A[Nbits-1];
        v_acc_d = 1'b0;
        cnt_d   = (B >= NB_W) ? SHW'(Nbits) : SHW'(B);
      end else begin
        state_d   = DONE;
        out_d     = imm_res;
        flags_d.c = imm_c;
        flags_d.v = imm_v;
        flags_d.z = (imm_res == '0);
        flags_d.n = imm_res[Nbits-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      work_q  <= '0;
      out_q   <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      v_acc_q <= 1'b0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      work_q  <= work_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      v_acc_q <= v_acc_d;
      flags_q <= flags_d;
    end
  end

  assign out_valid     = (state_q == DONE);
  assign OUT           = out_q;
  assign Carry_Flag    = flags_q.c;
  assign Overflow_Flag = flags_q.v;
  assign Zero_Flag     = flags_q.z;
  assign Negative_Flag = flags_q.n;

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq at Nbits=5: latency, result, flags, backpressure and reset.
module tb_alu_seq;

  localparam int NB = 5;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    ALUop;
  logic [NB-1:0] A;
  logic [NB-1:0] B;
  logic          out_valid;
  logic          out_ready;
  logic [NB-1:0] OUT;
  logic          Carry_Flag, Overflow_Flag, Zero_Flag, Negative_Flag;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0]    op;
    logic [NB-1:0] a;
    logic [NB-1:0] b;
    logic [NB-1:0] res;
    logic [3:0]    fl;   // {C,V,Z,N}
    int            lat;
  } vec_t;

  vec_t vecs[13];

  alu_seq #(.Nbits(NB)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .ALUop        (ALUop),
    .A            (A),
    .B            (B),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .OUT          (OUT),
    .Carry_Flag   (Carry_Flag),
    .Overflow_Flag(Overflow_Flag),
    .Zero_Flag    (Zero_Flag),
    .Negative_Flag(Negative_Flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] flags_now();
    return {Carry_Flag, Overflow_Flag, Zero_Flag, Negative_Flag};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one op with out_ready=1 and measure accept-to-out_valid latency.
  task automatic run_op(input int idx, input vec_t v);
    int lat;
    int ready_low;
    @(negedge clk);
    check_eq($sformatf("v%0d_in_ready", idx), in_ready, 1);
    in_valid  = 1'b1;
    ALUop     = v.op;
    A         = v.a;
    B         = v.b;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
    lat       = 1;
    ready_low = 0;
    while (!out_valid && lat < 40) begin
      if (!in_ready) ready_low++;
      @(negedge clk);
      lat++;
    end
    check_eq($sformatf("v%0d_latency", idx), lat, v.lat);
    check_eq($sformatf("v%0d_ready_low", idx), ready_low, v.lat - 1);
    check_eq($sformatf("v%0d_out", idx), OUT, v.res);
    check_eq($sformatf("v%0d_flags", idx), flags_now(), v.fl);
    $display("op=%0d A=%b B=%b -> OUT=%b CVZN=%b lat=%0d", v.op, v.a, v.b, OUT, flags_now(), lat);
  endtask

  initial begin
    int  lat;
    logic seen;
    vec_t opc12;

    vecs[0]  = '{4'd0, 5'd20,      5'd15,      5'd3,       4'b1000, 1}; // ADD carry out
    vecs[1]  = '{4'd1, 5'd3,       5'd5,       5'b11110,   4'b0001, 1}; // SUB borrow
    vecs[2]  = '{4'd0, 5'd15,      5'd1,       5'd16,      4'b0101, 1}; // ADD signed overflow
    vecs[3]  = '{4'd7, 5'b10011,   5'd2,       5'b01100,   4'b0000, 3}; // SLL by 2
    vecs[4]  = '{4'd8, 5'b10110,   5'd7,       5'b11111,   4'b1001, 6}; // SRA clamped to 5
    vecs[5]  = '{4'd9, 5'b01000,   5'd1,       5'b10000,   4'b0101, 2}; // SLA sign change
    vecs[6]  = '{4'd6, 5'b10001,   5'd5,       5'b00000,   4'b1010, 6}; // SRL by exactly Nbits
    vecs[7]  = '{4'd7, 5'b10110,   5'd0,       5'b10110,   4'b0001, 1}; // shift by 0
    vecs[8]  = '{4'd4, 5'b11111,   5'd9,       5'b00000,   4'b0010, 1}; // NOT
    vecs[9]  = '{4'd2, 5'b11100,   5'b10101,   5'b10100,   4'b0001, 1}; // AND
    vecs[10] = '{4'd3, 5'b00101,   5'b01000,   5'b01101,   4'b0000, 1}; // OR
    vecs[11] = '{4'd1, 5'd5,       5'd5,       5'd0,       4'b1010, 1}; // SUB equal -> Z, no borrow
    vecs[12] = '{4'd5, 5'b00110,   5'b00110,   5'd0,       4'b0010, 1}; // XOR self -> 0
    opc12    = '{4'd12, 5'd7,      5'd3,       5'd0,       4'b0010, 1}; // illegal opcode

    rst = 1'b1; in_valid = 1'b0; ALUop = '0; A = '0; B = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out", OUT, 0);
    check_eq("rst_flags", flags_now(), 0);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) run_op(i, vecs[i]);

    // Backpressure: XOR result held while out_ready is low, then a no-bubble follow-on.
    @(negedge clk);
    in_valid = 1'b1; ALUop = 4'd5; A = 5'b10101; B = 5'b01111; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("bp_valid", out_valid, 1);
    for (int c = 0; c < 4; c++) begin
      check_eq($sformatf("bp_hold%0d_out", c), OUT, 5'b11010);
      check_eq($sformatf("bp_hold%0d_ready", c), in_ready, 0);
      $display("bp hold cycle %0d OUT=%b valid=%b", c, OUT, out_valid);
      @(negedge clk);
    end
    check_eq("bp_still_valid", out_valid, 1);
    check_eq("bp_flags", flags_now(), 4'b0001);
    out_ready = 1'b1; in_valid = 1'b1; ALUop = 4'd0; A = 5'd1; B = 5'd2;
    #1;
    check_eq("bp_ready_on_release", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("bp_next_valid", out_valid, 1);
    check_eq("bp_next_out", OUT, 5'd3);
    $display("bp follow-on OUT=%b valid=%b", OUT, out_valid);

    // Reset in the second SHIFT cycle of an SRL by 4.
    @(negedge clk);
    in_valid = 1'b1; ALUop = 4'd6; A = 5'b10000; B = 5'd4; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("mid_shift_busy", in_ready, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_valid", out_valid, 0);
    check_eq("mid_rst_out", OUT, 0);
    check_eq("mid_rst_flags", flags_now(), 0);
    check_eq("mid_rst_ready", in_ready, 0);
    rst = 1'b0;
    #1;
    check_eq("post_rst_ready", in_ready, 1);
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check_eq("post_rst_no_result", seen, 0);
    $display("reset mid-shift: OUT=%b valid=%b", OUT, out_valid);

    run_op(13, opc12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
